// File: rtl/alu_seq_if.sv
// EX-stage decode and MDU sequencing bundle between the pipeline and alu_seq_controller.
// The master drives the instruction fields; the slave returns decode, stall and MDU control.
interface alu_seq_if;
    logic       id_valid;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       IsImm;
    logic       flush;
    logic [3:0] Operation;
    logic       illegal;
    logic       stall;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       mdu_done;
    logic       mdu_kill;

    modport master (
        output id_valid, ALUOp, Funct7, Funct3, IsImm, flush,
        input  Operation, illegal, stall, mdu_start, mdu_op, mdu_done, mdu_kill
    );

    modport slave (
        input  id_valid, ALUOp, Funct7, Funct3, IsImm, flush,
        output Operation, illegal, stall, mdu_start, mdu_op, mdu_done, mdu_kill
    );
endinterface

// File: rtl/alu_seq_controller.sv
// RISC-V EX-stage ALU operation decoder with a fixed-latency multiply/divide sequencer.
// Decode is combinational; M-ops are accepted in IDLE and held in EX via stall until done.
module alu_seq_controller #(
    parameter int M_EXT      = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_seq_if.slave   bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                           OP_SRA = 4'b0100, OP_XOR = 4'b0101, OP_SUB = 4'b0110,
                           OP_SLT = 4'b0111, OP_BEQ = 4'b1000, OP_SLL = 4'b1001,
                           OP_BLT = 4'b1010, OP_BGE = 4'b1011, OP_SRL = 4'b1101,
                           OP_BNE = 4'b1110, OP_LUI = 4'b1111;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MEXT = 7'b0000001;
    localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    dec_op;
    logic          dec_bad;
    logic          dec_mop;
    logic          accept;

    always_comb begin
        dec_op  = OP_ADD;
        dec_bad = 1'b0;
        dec_mop = 1'b0;
        case (bus.ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b11: dec_op = OP_LUI;
            2'b01: begin
                case (bus.Funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_bad = 1'b1;
                endcase
            end
            default: begin
                if (!bus.IsImm && bus.Funct7 == F7_MEXT) begin
                    if (M_EXT != 0) dec_mop = 1'b1;
                    else            dec_bad = 1'b1;
                end else if (!bus.IsImm && bus.Funct7 == F7_ALT) begin
                    if (bus.Funct3 == 3'b000)      dec_op  = OP_SUB;
                    else if (bus.Funct3 == 3'b101) dec_op  = OP_SRA;
                    else                           dec_bad = 1'b1;
                end else if (!bus.IsImm && bus.Funct7 != F7_BASE) begin
                    dec_bad = 1'b1;
                end else begin
                    // I-type immediates only constrain Funct7 for shifts
                    case (bus.Funct3)
                        3'b000: dec_op = OP_ADD;
                        3'b001: begin
                            if (bus.Funct7 == F7_BASE) dec_op  = OP_SLL;
                            else                       dec_bad = 1'b1;
                        end
                        3'b010: dec_op = OP_SLT;
                        3'b100: dec_op = OP_XOR;
                        3'b101: begin
                            if (bus.Funct7 == F7_BASE)     dec_op  = OP_SRL;
                            else if (bus.Funct7 == F7_ALT) dec_op  = OP_SRA;
                            else                           dec_bad = 1'b1;
                        end
                        3'b110: dec_op = OP_OR;
                        3'b111: dec_op = OP_AND;
                        default: dec_bad = 1'b1;
                    endcase
                end
            end
        endcase
        if (dec_bad || dec_mop) dec_op = OP_ADD;
    end

    assign accept        = (state == IDLE) && bus.id_valid && dec_mop && !bus.flush;
    assign bus.Operation = dec_op;
    assign bus.illegal   = bus.id_valid && dec_bad;
    assign bus.stall     = reset_n && (accept || state == BUSY);
    assign bus.mdu_done  = (state == DONE) && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mdu_start <= 1'b0;
            bus.mdu_op    <= 3'b000;
            bus.mdu_kill  <= 1'b0;
        end else begin
            bus.mdu_start <= 1'b0;
            bus.mdu_kill  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= BUSY;
                        bus.mdu_start <= 1'b1;
                        bus.mdu_op    <= bus.Funct3;
                        cnt           <= bus.Funct3[2] ? DIV_LAT : MUL_LAT;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state        <= IDLE;
                        bus.mdu_kill <= 1'b1;
                        cnt          <= '0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq_controller.md
# alu_seq_controller

Parametrised successor to the combinational ALU operation decoder in the RISC-V datapath EX stage. It decodes ALUOp/Funct3/Funct7 plus an explicit immediate flag into the 4-bit ALU Operation code, and flags unsupported encodings as illegal. It also sequences optional multi-cycle M-extension ops: it starts an external multiply/divide unit (MDU), counts its fixed latency, stalls the pipeline, and signals completion or abort on flush.

## Interface
- M_EXT, 1: 1 = decode MUL/DIV/REM (R-type, Funct7=0000001); 0 = those encodings are illegal.
- MUL_CYCLES, 2: MDU latency for Funct3[2]=0 ops; must be ≥1.
- DIV_CYCLES, 32: MDU latency for Funct3[2]=1 ops; must be ≥1. Counter width = $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  instruction present in EX this cycle.
- ALUOp  in  2  00 load/store/AUIPC, 01 branch, 10 R/I arithmetic, 11 LUI/JAL.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12.
- IsImm  in  1  1 = I-type arithmetic; Funct7 is immediate data except for shifts.
- flush  in  1  kill the instruction in EX.
- Operation  out  4  ALU operation code (combinational).
- illegal  out  1  id_valid & unsupported encoding (combinational).
- stall  out  1  hold IF/ID/EX.
- mdu_start  out  1  one-cycle registered start pulse.
- mdu_op  out  3  Funct3 captured at acceptance.
- mdu_done  out  1  MDU result valid; write back this cycle.
- mdu_kill  out  1  one-cycle registered abort pulse.

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, SRA 0100, XOR 0101, SUB 0110, SLT 0111, BEQ 1000, SLL 1001, BLT 1010, BGE 1011, SRL 1101, BNE 1110, LUI 1111.
- ALUOp 00 → ADD. ALUOp 11 → LUI. ALUOp 01: Funct3 000/001/100/101 → BEQ/BNE/BLT/BGE; others illegal.
- ALUOp 10, IsImm=0: Funct7 0000000 with Funct3 000..111 → ADD, SLL, SLT, illegal(011), XOR, SRL, OR, AND. Funct7 0100000 with Funct3 000 → SUB, 101 → SRA. Funct7 0000001 → M-op (if M_EXT). Any other combination is illegal.
- ALUOp 10, IsImm=1: Funct7 ignored except Funct3=001 (needs 0000000) and 101 (0000000 → SRL, 0100000 → SRA). 000 → ADD (never SUB), 010 → SLT, 011 illegal.
- Illegal encodings and M-ops drive Operation=0010.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept when id_valid & M-op & !flush. Then: state → BUSY, mdu_start=1 and mdu_op=Funct3 next cycle, cnt ← latency−1.
  - BUSY: if flush → IDLE, mdu_kill=1 next cycle. Else if cnt==0 → DONE. Else cnt−1.
  - DONE: always → IDLE. Inputs are ignored; the instruction leaves EX at the end of this cycle.
- stall = reset_n & ((IDLE & id_valid & M-op & !flush) | BUSY).
- mdu_done = DONE & !flush.
- Flush in the acceptance cycle: no acceptance, no stall.

## Timing
- Reset (async, reset_n low): state IDLE, cnt 0, mdu_start 0, mdu_op 000, mdu_kill 0, mdu_done 0, stall 0. Operation and illegal stay combinational.
- Reset mid-BUSY: immediately to IDLE, no mdu_done, no mdu_kill.
- M-op accepted at cycle T with latency L: BUSY T+1..T+L, mdu_start at T+1, DONE/mdu_done at T+L+1. stall is high T..T+L and low at T+L+1. EX occupancy is L+2 cycles.
- Back-to-back M-ops: the second is accepted in the IDLE cycle after DONE.
- Non-M instructions never stall; decode has zero latency.

## Test plan
- Decode sweep, id_valid=1: ALUOp=10, IsImm=0, Funct7=0100000, Funct3=000 → 0110. Same with IsImm=1 → 0010. ALUOp=01, Funct3=101 → 1011. ALUOp=11 → 1111. No stall in any case.
- Illegal: ALUOp=01, Funct3=110 → illegal=1, Operation=0010. R-type Funct7=0000001 with M_EXT=0 → illegal=1, stall=0.
- MUL, MUL_CYCLES=2, accepted at T: mdu_start at T+1, stall high T..T+2, mdu_done at T+3 only, mdu_op=000.
- DIV, DIV_CYCLES=32: mdu_done exactly 33 cycles after acceptance. Back-to-back REM: second mdu_start 2 cycles after the first mdu_done.
- Flush at BUSY cycle 5 of a DIV: mdu_kill pulse next cycle, state IDLE, no mdu_done, stall low the cycle after flush.
- reset_n low during BUSY: all registered outputs 0 asynchronously. After release with id_valid=0: IDLE, stall=0.
